fir_out_decim_fifo: RTL
=======================

Name: fir_out_decim_fifo

Overview:
Output stage placed directly downstream of the parallel FIR filter. It takes the 32-bit signed full-precision filter result and decimates it by DECIM. Each kept sample is rounded, shifted and saturated back to 16-bit signed. Results are buffered in a small first-word-fall-through FIFO with a valid/ready output handshake for the DAC/UART/capture logic that follows.

Parameters:
IN_W, 32, width of signed filter output accepted
OUT_W, 16, width of signed output sample
SHIFT, 15, arithmetic right shift applied after rounding (Q15 coefficients); legal 1..IN_W-OUT_W+1
DECIM, 4, decimation ratio; 1 = no decimation; legal 1..256
FIFO_DEPTH, 8, output buffer entries; power of two, >= 2

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_valid  in  1  in_data holds a new filter output this cycle
in_data  in  IN_W  signed filter output
out_valid  out  1  out_data holds a valid sample (FIFO not empty)
out_ready  in  1  consumer accepts out_data this cycle
out_data  out  OUT_W  signed rounded/saturated sample at FIFO head
fifo_level  out  $clog2(FIFO_DEPTH)+1  current number of stored samples
overflow  out  1  sticky; a decimated sample was dropped because the FIFO was full
sat_flag  out  1  sticky; at least one sample saturated
clr_flags  in  1  synchronous clear of overflow and sat_flag

Behaviour:
Interface: clock clk; reset rst_n, asynchronous, active-low.
- Reset: phase counter = 0, stage register invalid, FIFO empty (pointers 0), out_valid = 0, out_data = 0, fifo_level = 0, overflow = 0, sat_flag = 0. Reset mid-operation discards all buffered samples and restarts the phase.
- Decimation: a phase counter advances only on in_valid and counts 0..DECIM-1, wrapping to 0. A sample is kept only when in_valid = 1 and phase = 0. Cycles without in_valid do not advance the phase.
- Arithmetic, computed in IN_W+1 bits signed:
  - r = in_data + 2^(SHIFT-1) (round half up toward +inf).
  - q = r >>> SHIFT.
  - If q > 2^(OUT_W-1)-1, the result is 2^(OUT_W-1)-1; if q < -2^(OUT_W-1), the result is -2^(OUT_W-1); either case sets sat_flag.
  - Otherwise the result is q[OUT_W-1:0].
- Stage register: a kept sample accepted at the edge ending cycle t is held in the stage register with stage_valid during cycle t+1. It is written to the FIFO at the edge ending t+1. With the FIFO empty, out_valid = 1 and out_data = the sample in cycle t+2. Fixed latency is 2 cycles.
- FIFO push: occurs when stage_valid and (level < FIFO_DEPTH, or a pop occurs in the same cycle). Otherwise the sample is dropped and overflow is set; FIFO contents and level are unchanged.
- FIFO pop: occurs when out_valid and out_ready. out_data always shows the head entry, first-word-fall-through. out_data and out_valid stay stable while out_valid = 1 and out_ready = 0.
- Simultaneous push and pop: level is unchanged and the order is preserved. A full FIFO popping and pushing in the same cycle does not overflow.
- fifo_level update: increments on push only, decrements on pop only, and is unchanged on both or neither. It never exceeds FIFO_DEPTH and never underflows; out_ready with an empty FIFO is ignored.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH.
- Flags: clr_flags clears both sticky flags at the next edge. If a saturation or overflow event occurs in the same cycle as clr_flags, the event wins and the flag stays/becomes 1.
- out_data holds its last value when the FIFO goes empty; out_valid = 0 in that case.

Decomposition:
- Shared package fir_pkg holds:
  - constants FIR_DATA_W = 16 and FIR_ACC_W = 32, shared with the filter;
  - function sat_round(value, shift, out_w) returning the saturated result and a saturation bit.
- One sub-module, fir_sync_fifo: parameterised width/depth, synchronous, first-word-fall-through, with push/pop/full/empty/level ports.
- Top level contains the phase counter, the rounding/saturation stage register and the flags.

Test Plan:
1. Defaults, DECIM = 1, out_ready = 1. in_data = 16384 then -16385 then 49151 → out_data = 1, then -1, then 1 (49151 + 16384 = 65535, >>15 = 1), each 2 cycles after input; sat_flag = 0.
2. Saturation. in_data = 0x7FFFFFFF then 0x80000000 → out_data = 32767 then -32768, sat_flag = 1. Pulse clr_flags with no event → sat_flag = 0 next cycle.
3. Decimation, DECIM = 4. Feed in_data = k<<15 for k = 0..11, with in_valid gapped every other cycle → outputs exactly 0, 4, 8; phase stays frozen during gaps.
4. Overflow. out_ready = 0, DECIM = 4, 40 consecutive valid inputs → 10 kept samples, fifo_level = 8, overflow = 1. Then raise out_ready → the 8 oldest kept samples emerge in order, and out_valid drops after 8 pops.
5. Full-FIFO concurrency. FIFO full with out_ready = 1 held while kept samples keep arriving every cycle (DECIM = 1) → level stays 8, overflow stays 0, no sample lost or reordered.
6. Reset mid-stream. Assert rst_n = 0 asynchronously with level = 5 → out_valid, fifo_level and out_data go to 0 immediately. After release, the first kept sample is the first in_valid sample (phase restarted at 0).

Source files
------------

// File: rtl/fir_pkg.sv
// Constants shared with the parallel FIR filter, plus the output rounding/saturation helper.
package fir_pkg;

    localparam int unsigned FIR_DATA_W = 16;
    localparam int unsigned FIR_ACC_W  = 32;

    // Working width for sat_round; wide enough for any legal IN_W+1 intermediate.
    localparam int unsigned SR_W = 64;

    typedef struct packed {
        logic                   sat;
        logic signed [SR_W-1:0] value;
    } sat_round_t;

    // Round half up, arithmetic shift right, then clamp to the signed out_w range.
    function automatic sat_round_t sat_round(
        input logic signed [SR_W-1:0] value,
        input int unsigned            shift,
        input int unsigned            out_w
    );
        logic signed [SR_W-1:0] rnd;
        logic signed [SR_W-1:0] r;
        logic signed [SR_W-1:0] q;
        logic signed [SR_W-1:0] hi;
        logic signed [SR_W-1:0] lo;
        sat_round_t             res;

        rnd            = '0;
        rnd[shift-1]   = 1'b1;
        r              = value + rnd;
        q              = r >>> shift;
        hi             = '0;
        hi[out_w-1]    = 1'b1;
        hi             = hi - 64'sd1;
        lo             = -hi - 64'sd1;

        res.sat   = 1'b0;
        res.value = q;
        if (q > hi) begin
            res.sat   = 1'b1;
            res.value = hi;
        end else if (q < lo) begin
            res.sat   = 1'b1;
            res.value = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head value is held after the last pop.
module fir_sync_fifo #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;

    // Once empty, keep presenting the most recently popped word instead of stale memory.
    assign dout_o  = empty_o ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        last_d   = last_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            last_d   = mem_q[rd_ptr_q];
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/fir_out_decim_fifo.sv
// FIR output stage: decimate, round/shift/saturate to OUT_W, buffer in a FWFT FIFO.
module fir_out_decim_fifo
    import fir_pkg::*;
#(
    parameter  int unsigned IN_W       = FIR_ACC_W,
    parameter  int unsigned OUT_W      = FIR_DATA_W,
    parameter  int unsigned SHIFT      = 15,
    parameter  int unsigned DECIM      = 4,
    parameter  int unsigned FIFO_DEPTH = 8,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic [LVL_W-1:0]        fifo_level,
    output logic                    overflow,
    output logic                    sat_flag,
    input  logic                    clr_flags
);

    localparam int unsigned      PH_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(DECIM - 1);

    logic [PH_W-1:0]  phase_q, phase_d;
    logic             stage_valid_q, stage_valid_d;
    logic [OUT_W-1:0] stage_data_q, stage_data_d;
    logic             overflow_q, overflow_d;
    logic             sat_q, sat_d;

    logic [SR_W-1:0]  wide;
    sat_round_t       sr;
    logic             keep;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OUT_W-1:0] fifo_dout;
    logic             ovf_evt;
    logic             sat_evt;

    always_comb begin
        wide = {{(SR_W - IN_W){in_data[IN_W-1]}}, in_data};
        sr   = sat_round(wide, SHIFT, OUT_W);
        keep = in_valid && (phase_q == '0);

        phase_d = phase_q;
        if (in_valid) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        end

        stage_valid_d = keep;
        stage_data_d  = keep ? sr.value[OUT_W-1:0] : stage_data_q;

        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        fifo_pop  = !fifo_empty && out_ready;
        fifo_push = stage_valid_q && (!fifo_full || fifo_pop);

        ovf_evt = stage_valid_q && !fifo_push;
        sat_evt = keep && sr.sat;

        // Events take priority over a coincident clear.
        overflow_d = (overflow_q && !clr_flags) || ovf_evt;
        sat_d      = (sat_q && !clr_flags) || sat_evt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= '0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            overflow_q    <= 1'b0;
            sat_q         <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            overflow_q    <= overflow_d;
            sat_q         <= sat_d;
        end
    end

    fir_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (stage_data_q),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_dout;
    assign overflow  = overflow_q;
    assign sat_flag  = sat_q;

endmodule
